io_uart: RTL and testbench

IO_UART -- requirements
Module: io_uart

---
 rtl/io_uart_if.sv | 33 +++
 rtl/io_uart.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_io_uart.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/io_uart_if.sv
// Pin/bus bundle for io_uart: serial lines, error request, decoded command pulses and clock digits.
interface io_uart_if;
  logic       rx;
  logic       tx;
  logic       er;
  logic       is_start_cmd;
  logic       is_check_cmd;
  logic       is_reset_cmd;
  logic       is_setcl_cmd;
  logic       is_exit_cmd;
  logic       is_shutdown_cmd;
  logic       wr_ry;
  logic [3:0] clock1;
  logic [3:0] clock2;
  logic [3:0] clock3;
  logic [3:0] clock4;
  logic [3:0] clock5;
  logic [3:0] clock6;

  modport slave (
    input  rx, er,
    output tx, is_start_cmd, is_check_cmd, is_reset_cmd, is_setcl_cmd,
           is_exit_cmd, is_shutdown_cmd, wr_ry,
           clock1, clock2, clock3, clock4, clock5, clock6
  );

  modport master (
    output rx, er,
    input  tx, is_start_cmd, is_check_cmd, is_reset_cmd, is_setcl_cmd,
           is_exit_cmd, is_shutdown_cmd, wr_ry,
           clock1, clock2, clock3, clock4, clock5, clock6
  );
endinterface

// File: rtl/io_uart.sv
// Text-command UART: 8N1 line receiver with command/digit decoder, and an ERR message transmitter.
// Define IO_UART_ACK_EN to also answer every recognized line with "OK\r\n".
module io_uart #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input logic      clk,
  input logic      rst_n,
  io_uart_if.slave bus
);

  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);

  localparam logic [3:0] ERR_FIRST = 4'd0;
  localparam logic [3:0] ERR_LAST  = 4'd4;
  localparam logic [3:0] OK_FIRST  = 4'd5;
  localparam logic [3:0] OK_LAST   = 4'd8;

`ifdef IO_UART_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  // state    | meaning
  // RX_IDLE  | waiting for falling edge on synchronized rx
  // RX_START | counting to mid start bit, re-check low
  // RX_DATA  | sampling 8 data bits LSB first at mid-bit
  // RX_STOP  | sampling stop bit; high delivers the byte
  // TX_IDLE  | line high, waiting for a pending message
  // TX_START | driving start bit
  // TX_DATA  | shifting out 8 data bits LSB first
  // TX_STOP  | driving stop bit, then next byte/message or idle
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  // Reset to 0 so a line held low through reset release is not taken as an edge.
  logic rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic rx_fall;

  always_comb begin
    rx_meta_d = bus.rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_vld_q, byte_vld_d;
  logic [7:0]      byte_q, byte_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else if (rx_sync_q) rx_state_d = RX_IDLE;
        else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = BIT_LAST;
          rx_bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_vld_d = 1'b1;
            byte_d     = rx_shift_q;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  logic [7:0] line_q [16];
  logic [7:0] line_d [16];
  logic [4:0] len_q, len_d;
  logic       ovf_q, ovf_d;
  logic [5:0] cmd_q, cmd_d;
  logic       wr_ry_q, wr_ry_d;
  logic [3:0] dig_q [6];
  logic [3:0] dig_d [6];
  logic       digits_ok;
  logic       is_term;
  logic       line_hit;

  // s holds the command left-aligned, first character in the top byte.
  function automatic logic line_is(input logic [63:0] s, input logic [4:0] n);
    logic ok;
    ok = (len_q == n);
    for (int i = 0; i < 8; i++) begin
      if (5'(i) < n) ok = ok & (line_q[i] == s[63 - 8*i -: 8]);
    end
    return ok;
  endfunction

  always_comb begin
    digits_ok = (len_q == 5'd6);
    for (int i = 0; i < 6; i++) begin
      if (line_q[i] < 8'h30 || line_q[i] > 8'h39) digits_ok = 1'b0;
    end
  end

  assign is_term = (byte_q == 8'h0D) || (byte_q == 8'h0A);

  always_comb begin
    line_d  = line_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    cmd_d   = 6'b0;
    wr_ry_d = 1'b0;
    dig_d   = dig_q;
    if (byte_vld_q) begin
      if (is_term) begin
        len_d = 5'd0;
        ovf_d = 1'b0;
        if (!ovf_q && len_q != 5'd0) begin
          cmd_d[0] = line_is({"start", 24'h0}, 5'd5);
          cmd_d[1] = line_is({"check", 24'h0}, 5'd5);
          cmd_d[2] = line_is({"reset", 24'h0}, 5'd5);
          cmd_d[3] = line_is({"setcl", 24'h0}, 5'd5);
          cmd_d[4] = line_is({"exit", 32'h0}, 5'd4);
          cmd_d[5] = line_is("shutdown", 5'd8);
          if (digits_ok) begin
            wr_ry_d = 1'b1;
            for (int i = 0; i < 6; i++) dig_d[i] = line_q[i][3:0];
          end
        end
      end else if (!ovf_q) begin
        if (len_q == 5'd16) begin
          ovf_d = 1'b1;
          len_d = 5'd0;
        end else begin
          line_d[len_q[3:0]] = byte_q;
          len_d              = len_q + 5'd1;
        end
      end
    end
  end

  assign line_hit = (|cmd_d) | wr_ry_d;

  function automatic logic [7:0] msg_rom(input logic [3:0] a);
    case (a)
      4'd0:    return 8'h45;
      4'd1:    return 8'h52;
      4'd2:    return 8'h52;
      4'd3:    return 8'h0D;
      4'd4:    return 8'h0A;
      4'd5:    return 8'h4F;
      4'd6:    return 8'h4B;
      4'd7:    return 8'h0D;
      4'd8:    return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [3:0]    tx_addr_q, tx_addr_d;
  logic [3:0]    tx_last_q, tx_last_d;
  logic          err_pend_q, err_pend_d;
  logic          ack_pend_q, ack_pend_d;
  logic          tx_q, tx_d;
  logic          load_next;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_addr_d  = tx_addr_q;
    tx_last_d  = tx_last_q;
    err_pend_d = err_pend_q | bus.er;
    ack_pend_d = ack_pend_q | (ACK_EN & line_hit);
    load_next  = 1'b0;
    case (tx_state_q)
      TX_IDLE: load_next = 1'b1;
      TX_START: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 1'b1;
        else begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = 3'd0;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 1'b1;
        else begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 1'b1;
        else if (tx_addr_q != tx_last_q) begin
          tx_addr_d  = tx_addr_q + 4'd1;
          tx_shift_d = msg_rom(tx_addr_q + 4'd1);
          tx_state_d = TX_START;
          tx_cnt_d   = BIT_LAST;
        end else begin
          tx_state_d = TX_IDLE;
          load_next  = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Launching straight from the stop bit keeps queued messages back-to-back.
    if (load_next) begin
      if (err_pend_q) begin
        err_pend_d = bus.er;
        tx_addr_d  = ERR_FIRST;
        tx_last_d  = ERR_LAST;
        tx_shift_d = msg_rom(ERR_FIRST);
        tx_state_d = TX_START;
        tx_cnt_d   = BIT_LAST;
      end else if (ack_pend_q) begin
        ack_pend_d = ACK_EN & line_hit;
        tx_addr_d  = OK_FIRST;
        tx_last_d  = OK_LAST;
        tx_shift_d = msg_rom(OK_FIRST);
        tx_state_d = TX_START;
        tx_cnt_d   = BIT_LAST;
      end
    end
    if (tx_state_d == TX_START)     tx_d = 1'b0;
    else if (tx_state_d == TX_DATA) tx_d = tx_shift_d[0];
    else                            tx_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_meta_q  <= 1'b0;
      rx_sync_q  <= 1'b0;
      rx_prev_q  <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'h00;
      for (int i = 0; i < 16; i++) line_q[i] <= 8'h00;
      len_q      <= 5'd0;
      ovf_q      <= 1'b0;
      cmd_q      <= 6'b0;
      wr_ry_q    <= 1'b0;
      for (int i = 0; i < 6; i++) dig_q[i] <= 4'd0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_addr_q  <= 4'd0;
      tx_last_q  <= 4'd0;
      err_pend_q <= 1'b0;
      ack_pend_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      line_q     <= line_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      cmd_q      <= cmd_d;
      wr_ry_q    <= wr_ry_d;
      dig_q      <= dig_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_addr_q  <= tx_addr_d;
      tx_last_q  <= tx_last_d;
      err_pend_q <= err_pend_d;
      ack_pend_q <= ack_pend_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.tx              = tx_q;
  assign bus.is_start_cmd    = cmd_q[0];
  assign bus.is_check_cmd    = cmd_q[1];
  assign bus.is_reset_cmd    = cmd_q[2];
  assign bus.is_setcl_cmd    = cmd_q[3];
  assign bus.is_exit_cmd     = cmd_q[4];
  assign bus.is_shutdown_cmd = cmd_q[5];
  assign bus.wr_ry           = wr_ry_q;
  assign bus.clock1          = dig_q[0];
  assign bus.clock2          = dig_q[1];
  assign bus.clock3          = dig_q[2];
  assign bus.clock4          = dig_q[3];
  assign bus.clock5          = dig_q[4];
  assign bus.clock6          = dig_q[5];

endmodule

// File: tb/tb_io_uart.sv
// Directed bench for io_uart at 16 clocks per bit: command/digit decode, ERR transmit, reset.
module tb_io_uart;
  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int BIT    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic rst_n;
  io_uart_if bus();

  io_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int          tests  = 0;
  int          failed = 0;
  int          cyc    = 0;
  logic [31:0] ev_acc = 32'h0;
  logic [23:0] dig_at_wr = 24'h0;
  logic [6:0]  ev_vec;
  logic [8:0]  tx_bytes[$];
  int          tx_stamp[$];

  always @(posedge clk) cyc++;

  // Each high cycle of a pulse adds one hex code: 1 start 2 check 3 reset 4 setcl 5 exit 6 shutdown 7 wr_ry.
  always @(negedge clk) begin
    ev_vec = {bus.wr_ry, bus.is_shutdown_cmd, bus.is_exit_cmd, bus.is_setcl_cmd,
              bus.is_reset_cmd, bus.is_check_cmd, bus.is_start_cmd};
    for (int k = 0; k < 7; k++) begin
      if (ev_vec[k] === 1'b1) ev_acc = {ev_acc[27:0], 4'(k + 1)};
    end
    if (bus.wr_ry === 1'b1)
      dig_at_wr = {bus.clock1, bus.clock2, bus.clock3, bus.clock4, bus.clock5, bus.clock6};
  end

  initial begin : tx_mon
    logic [7:0] b;
    logic       stp;
    int         st;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.tx === 1'b0) begin
        st = cyc;
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = bus.tx;
        end
        repeat (BIT) @(negedge clk);
        stp = bus.tx;
        tx_bytes.push_back({stp, b});
        tx_stamp.push_back(st);
      end
    end
  end

  initial begin : watchdog
    #900us;
    $display("FAIL watchdog: observed no finish, expected finish before 900us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      wait_bits(1);
    end
    bus.rx = stop_bit;
    wait_bits(1);
    bus.rx = 1'b1;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    wait_bits(3);
  endtask

  task automatic check_ev(input string tag, input logic [31:0] exp);
    chk(tag, ev_acc, exp);
    ev_acc = 32'h0;
  endtask

  function automatic logic [31:0] digits_now();
    return {8'h0, bus.clock1, bus.clock2, bus.clock3, bus.clock4, bus.clock5, bus.clock6};
  endfunction

  task automatic pulse_er();
    @(negedge clk);
    bus.er = 1'b1;
    @(negedge clk);
    bus.er = 1'b0;
  endtask

  logic [7:0] err_msg [5];

  initial begin : stim
    err_msg = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    bus.er = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_tx", 32'(bus.tx), 32'h1);
    chk("reset_pulses", 32'(ev_vec), 32'h0);
    chk("reset_digits", digits_now(), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    ev_acc = 32'h0;

    send_line("start\r\n");
    check_ev("start_crlf", 32'h1);

    send_line("123456\n");
    check_ev("digits_pulse", 32'h7);
    chk("digits_at_wr", 32'(dig_at_wr), 32'h123456);
    chk("digits_held", digits_now(), 32'h123456);

    send_line("12a456\n");
    check_ev("bad_digits_pulse", 32'h0);
    chk("bad_digits_held", digits_now(), 32'h123456);

    send_line("987654\n");
    check_ev("digits2_pulse", 32'h7);
    chk("digits2_value", digits_now(), 32'h987654);

    send_line("1234567\n");
    check_ev("seven_digits_pulse", 32'h0);
    chk("seven_digits_held", digits_now(), 32'h987654);

    send_line("check\n");
    send_line("exit\n");
    send_line("setcl\n");
    send_line("shutdown\n");
    send_line("reset\n");
    check_ev("cmd_sequence", 32'h25463);

    send_line("Start\n");
    send_line("checkx\n");
    check_ev("near_miss", 32'h0);

    send_line("aaaaaaaaaaaaaaaaaaaa\n");
    check_ev("overflow_line", 32'h0);
    send_line("exit\n");
    check_ev("after_overflow_exit", 32'h5);

    send_byte("x", 1'b0);
    wait_bits(2);
    send_line("exit\n");
    check_ev("framing_discard_exit", 32'h5);

    tx_bytes.delete();
    tx_stamp.delete();
    pulse_er();
    wait_bits(3);
    pulse_er();
    wait_bits(2);
    pulse_er();
    for (int k = 0; k < 4000 && tx_bytes.size() < 10; k++) @(negedge clk);
    chk("tx_byte_count", 32'(tx_bytes.size()), 32'd10);
    if (tx_bytes.size() == 10) begin
      for (int i = 0; i < 10; i++) chk($sformatf("tx_byte%0d", i), 32'(tx_bytes[i]), {23'h0, 1'b1, err_msg[i % 5]});
      for (int i = 0; i < 9; i++) chk($sformatf("tx_gap%0d", i), 32'(tx_stamp[i + 1] - tx_stamp[i]), 32'(10 * BIT));
    end
    wait_bits(4);
    chk("tx_idle_after", 32'(bus.tx), 32'h1);
    chk("tx_no_extra", 32'(tx_bytes.size()), 32'd10);

    bus.rx = 1'b0;
    wait_bits(1);
    bus.rx = 1'b1;
    wait_bits(1);
    bus.rx = 1'b0;
    wait_bits(2);
    rst_n = 1'b0;
    #1;
    chk("midbyte_reset_tx", 32'(bus.tx), 32'h1);
    chk("midbyte_reset_digits", digits_now(), 32'h0);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    ev_acc = 32'h0;
    send_line("start\n");
    check_ev("start_after_reset", 32'h1);
    chk("digits_after_reset", digits_now(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
